// File: rtl/pciecfg_pkg.sv
// rtl/pciecfg_pkg.sv - shared types and default sizing for the PCIe config arbiter
package pciecfg_pkg;
    typedef logic [31:0] FIFO_PCIECFG_T;

    localparam int CFG_W           = $bits(FIFO_PCIECFG_T);
    localparam int PCIECFG_NREQ    = 2;
    localparam int PCIECFG_MAX_OUT = 4;
endpackage

// File: rtl/pciecfg_tagq.sv
// rtl/pciecfg_tagq.sv - in-order FIFO of requester tags for outstanding config requests
module pciecfg_tagq #(
    parameter int DEPTH = 4,
    parameter int TW    = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [TW-1:0]            push_tag,
    input  logic                     pop,
    output logic [TW-1:0]            head,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [TW-1:0] mem_q [DEPTH];
    logic [TW-1:0] mem_d [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == (AW+1)'(DEPTH));
    assign head  = mem_q[rd_q];
    assign count = cnt_q;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // DEPTH is a power of two, so the pointers wrap naturally
    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (do_push) begin
            mem_d[wr_q] = push_tag;
            wr_d        = wr_q + 1'b1;
        end
        if (do_pop) begin
            rd_d = rd_q + 1'b1;
        end
        cnt_d = cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            mem_q <= mem_d;
        end
    end
endmodule

// File: rtl/pciecfg_arb.sv
// rtl/pciecfg_arb.sv - round-robin sharing of the PCIe config engine among NREQ requesters
module pciecfg_arb
    import pciecfg_pkg::*;
#(
    parameter int NREQ    = PCIECFG_NREQ,
    parameter int MAX_OUT = PCIECFG_MAX_OUT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_empty,
    output logic [NREQ-1:0]           req_rd_en,
    input  logic [NREQ*CFG_W-1:0]     req_dout,
    output logic                      cfg_wr_en,
    input  logic                      cfg_full,
    output logic [CFG_W-1:0]          cfg_din,
    output logic                      cfg_rd_en,
    input  logic                      cfg_empty,
    input  logic [CFG_W-1:0]          cfg_dout,
    output logic [NREQ-1:0]           rsp_wr_en,
    input  logic [NREQ-1:0]           rsp_full,
    output logic [CFG_W-1:0]          rsp_din,
    output logic [$clog2(MAX_OUT):0]  outstanding,
    output logic                      err_orphan
);
    localparam int TW = $clog2(NREQ);

    logic             stg_valid_q, stg_valid_d;
    logic [CFG_W-1:0] stg_data_q, stg_data_d;
    logic [TW-1:0]    rr_ptr_q, rr_ptr_d;
    logic             err_orphan_q, err_orphan_d;

    logic [2*NREQ-1:0] avail2;
    logic [TW-1:0]     grant;
    logic              found, can_load, issue;
    logic [TW-1:0]     tq_head;
    logic              tq_empty, tq_full, head_full, deliver, orphan;

    // Doubling the request vector lets a single ascending scan start at rr_ptr+1
    always_comb begin
        avail2 = {~req_empty, ~req_empty};
        found  = 1'b0;
        grant  = '0;
        for (int j = 2*NREQ-1; j >= 0; j--) begin
            if (j > int'(rr_ptr_q) && j <= int'(rr_ptr_q) + NREQ && avail2[j]) begin
                found = 1'b1;
                grant = TW'(j % NREQ);
            end
        end
    end

    always_comb begin
        cfg_wr_en   = stg_valid_q & ~cfg_full;
        cfg_din     = stg_data_q;
        can_load    = ~stg_valid_q | cfg_wr_en;
        issue       = can_load & ~tq_full & found;

        req_rd_en   = '0;
        stg_valid_d = stg_valid_q;
        stg_data_d  = stg_data_q;
        rr_ptr_d    = rr_ptr_q;
        if (can_load) begin
            stg_valid_d = issue;
        end
        for (int i = 0; i < NREQ; i++) begin
            if (issue && grant == TW'(i)) begin
                req_rd_en[i] = 1'b1;
                stg_data_d   = req_dout[i*CFG_W +: CFG_W];
            end
        end
        if (issue) begin
            rr_ptr_d = grant;
        end

        head_full = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (tq_head == TW'(i) && rsp_full[i]) begin
                head_full = 1'b1;
            end
        end
        deliver   = ~tq_empty & ~cfg_empty & ~head_full;
        orphan    = tq_empty & ~cfg_empty;
        cfg_rd_en = deliver | orphan;
        rsp_din   = deliver ? cfg_dout : '0;
        rsp_wr_en = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (deliver && tq_head == TW'(i)) begin
                rsp_wr_en[i] = 1'b1;
            end
        end
        err_orphan_d = err_orphan_q | orphan;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stg_valid_q  <= 1'b0;
            stg_data_q   <= '0;
            rr_ptr_q     <= TW'(NREQ - 1);
            err_orphan_q <= 1'b0;
        end else begin
            stg_valid_q  <= stg_valid_d;
            stg_data_q   <= stg_data_d;
            rr_ptr_q     <= rr_ptr_d;
            err_orphan_q <= err_orphan_d;
        end
    end

    assign err_orphan = err_orphan_q;

    // Tag count doubles as the outstanding-request counter
    pciecfg_tagq #(
        .DEPTH (MAX_OUT),
        .TW    (TW)
    ) u_tagq (
        .clk      (clk),
        .rst      (rst),
        .push     (issue),
        .push_tag (grant),
        .pop      (deliver),
        .head     (tq_head),
        .empty    (tq_empty),
        .full     (tq_full),
        .count    (outstanding)
    );
endmodule

// File: tb/tb_pciecfg_arb.sv
// tb/tb_pciecfg_arb.sv - self-checking bench for pciecfg_arb
module tb_pciecfg_arb;
    import pciecfg_pkg::*;

    localparam int NREQ    = 2;
    localparam int MAX_OUT = 4;
    localparam int OW      = $clog2(MAX_OUT) + 1;
    localparam logic [31:0] KEY = 32'h5A5A_0000;

    logic              clk, rst;
    logic [NREQ-1:0]   req_empty, req_rd_en, rsp_wr_en, rsp_full;
    logic [NREQ*32-1:0] req_dout;
    logic              cfg_wr_en, cfg_full, cfg_rd_en, cfg_empty, err_orphan;
    logic [31:0]       cfg_din, cfg_dout, rsp_din;
    logic [OW-1:0]     outstanding;

    pciecfg_arb #(.NREQ(NREQ), .MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .rst(rst),
        .req_empty(req_empty), .req_rd_en(req_rd_en), .req_dout(req_dout),
        .cfg_wr_en(cfg_wr_en), .cfg_full(cfg_full), .cfg_din(cfg_din),
        .cfg_rd_en(cfg_rd_en), .cfg_empty(cfg_empty), .cfg_dout(cfg_dout),
        .rsp_wr_en(rsp_wr_en), .rsp_full(rsp_full), .rsp_din(rsp_din),
        .outstanding(outstanding), .err_orphan(err_orphan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Environment: FWFT request FIFOs, loopback engine, response scoreboard
    typedef struct { int who; logic [31:0] data; } sb_t;
    logic [31:0] rq0[$], rq1[$], eng_out[$];
    sb_t         sb[$];
    int          grants[$];
    bit          hold_rsp, force_full;
    logic [1:0]  rsp_full_v;
    int          orphans_seen;

    task automatic drive_env();
        req_empty = {rq1.size() == 0, rq0.size() == 0};
        req_dout  = '0;
        if (rq0.size() != 0) req_dout[31:0]  = rq0[0];
        if (rq1.size() != 0) req_dout[63:32] = rq1[0];
        cfg_full  = force_full;
        cfg_empty = hold_rsp || eng_out.size() == 0;
        cfg_dout  = (eng_out.size() != 0) ? eng_out[0] : 32'h0;
        rsp_full  = rsp_full_v;
    endtask

    task automatic observe();
        sb_t e;
        logic [31:0] w;
        check("rd_onehot", 32'($countones(req_rd_en) <= 1), 32'd1);
        if (cfg_wr_en) eng_out.push_back(cfg_din ^ KEY);
        if (req_rd_en[0]) begin
            w = rq0.pop_front();
            sb.push_back('{0, w ^ KEY});
            grants.push_back(0);
        end
        if (req_rd_en[1]) begin
            w = rq1.pop_front();
            sb.push_back('{1, w ^ KEY});
            grants.push_back(1);
        end
        if (cfg_rd_en) begin
            if (eng_out.size() == 0) begin
                check("rd_on_empty_engine", 32'd1, 32'd0);
            end else begin
                w = eng_out.pop_front();
                if (rsp_wr_en != 0) begin
                    if (sb.size() == 0) begin
                        check("rsp_without_request", 32'(rsp_wr_en), 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check("rsp_target", 32'(rsp_wr_en), 32'd1 << e.who);
                        check("rsp_data", rsp_din, e.data);
                    end
                end else begin
                    orphans_seen++;
                end
            end
        end else if (rsp_wr_en != 0) begin
            check("rsp_wr_without_rd", 32'(rsp_wr_en), 32'd0);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1 drive_env();
        #1 observe();
    endtask

    task automatic drain(input int maxc);
        int k;
        k = 0;
        while ((rq0.size() + rq1.size() + sb.size() + eng_out.size()) != 0 && k < maxc) begin
            cyc();
            k++;
        end
        check("drain_done", 32'(rq0.size() + rq1.size() + sb.size() + eng_out.size()), 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        rq0.delete(); rq1.delete(); eng_out.delete(); sb.delete(); grants.delete();
        hold_rsp = 0; force_full = 0; rsp_full_v = 2'b00;
        drive_env();
        @(posedge clk);
        #1 rst = 1'b0;
        drive_env();
        #1;
        check("rst_req_rd_en", 32'(req_rd_en), 32'd0);
        check("rst_cfg_wr_en", 32'(cfg_wr_en), 32'd0);
        check("rst_cfg_rd_en", 32'(cfg_rd_en), 32'd0);
        check("rst_rsp_wr_en", 32'(rsp_wr_en), 32'd0);
        check("rst_cfg_din", cfg_din, 32'd0);
        check("rst_rsp_din", rsp_din, 32'd0);
        check("rst_outstanding", 32'(outstanding), 32'd0);
        check("rst_err_orphan", 32'(err_orphan), 32'd0);
    endtask

    typedef struct {
        logic [1:0]  re;
        logic [31:0] d0, d1;
        logic        cf, ce;
        logic [31:0] cd;
        logic [1:0]  rf;
        logic [1:0]  x_rd;
        logic        x_wr;
        logic [31:0] x_din;
        logic        x_crd;
        logic [1:0]  x_rsp;
        logic [31:0] x_rdin;
        logic [2:0]  x_out;
        logic        x_err;
    } vec_t;

    vec_t vt[12];

    initial begin
        int pops;

        //            re     d0     d1     cf ce cd     rf  | rd    wr din    crd rsp   rdin   out err
        vt[0]  = '{2'b11, 32'h0,  32'h0,  0, 1, 32'h0,  2'b00, 2'b00, 0, 32'h0,  0, 2'b00, 32'h0,  3'd0, 0};
        vt[1]  = '{2'b10, 32'hA1, 32'h0,  0, 1, 32'h0,  2'b00, 2'b01, 0, 32'h0,  0, 2'b00, 32'h0,  3'd0, 0};
        vt[2]  = '{2'b11, 32'h0,  32'h0,  0, 1, 32'h0,  2'b00, 2'b00, 1, 32'hA1, 0, 2'b00, 32'h0,  3'd1, 0};
        vt[3]  = '{2'b11, 32'h0,  32'h0,  0, 1, 32'h0,  2'b00, 2'b00, 0, 32'hA1, 0, 2'b00, 32'h0,  3'd1, 0};
        vt[4]  = '{2'b11, 32'h0,  32'h0,  0, 0, 32'hB1, 2'b00, 2'b00, 0, 32'hA1, 1, 2'b01, 32'hB1, 3'd1, 0};
        vt[5]  = '{2'b11, 32'h0,  32'h0,  0, 1, 32'h0,  2'b00, 2'b00, 0, 32'hA1, 0, 2'b00, 32'h0,  3'd0, 0};
        vt[6]  = '{2'b11, 32'h0,  32'h0,  0, 0, 32'hC3, 2'b00, 2'b00, 0, 32'hA1, 1, 2'b00, 32'h0,  3'd0, 0};
        vt[7]  = '{2'b11, 32'h0,  32'h0,  0, 1, 32'h0,  2'b00, 2'b00, 0, 32'hA1, 0, 2'b00, 32'h0,  3'd0, 1};
        vt[8]  = '{2'b00, 32'hD0, 32'hD1, 0, 1, 32'h0,  2'b00, 2'b10, 0, 32'hA1, 0, 2'b00, 32'h0,  3'd0, 1};
        vt[9]  = '{2'b00, 32'hD0, 32'hD1, 0, 1, 32'h0,  2'b00, 2'b01, 1, 32'hD1, 0, 2'b00, 32'h0,  3'd1, 1};
        vt[10] = '{2'b11, 32'h0,  32'h0,  0, 1, 32'h0,  2'b00, 2'b00, 1, 32'hD0, 0, 2'b00, 32'h0,  3'd2, 1};
        vt[11] = '{2'b10, 32'hE0, 32'h0,  1, 1, 32'h0,  2'b00, 2'b01, 0, 32'hD0, 0, 2'b00, 32'h0,  3'd2, 1};

        rst = 1'b1;
        hold_rsp = 0; force_full = 0; rsp_full_v = 2'b00; orphans_seen = 0;
        drive_env();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Single request, response, orphan and round-robin start, one row per cycle
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            req_empty = vt[i].re;
            req_dout  = {vt[i].d1, vt[i].d0};
            cfg_full  = vt[i].cf;
            cfg_empty = vt[i].ce;
            cfg_dout  = vt[i].cd;
            rsp_full  = vt[i].rf;
            #1;
            check($sformatf("vec%0d_req_rd_en", i), 32'(req_rd_en), 32'(vt[i].x_rd));
            check($sformatf("vec%0d_cfg_wr_en", i), 32'(cfg_wr_en), 32'(vt[i].x_wr));
            check($sformatf("vec%0d_cfg_din", i), cfg_din, vt[i].x_din);
            check($sformatf("vec%0d_cfg_rd_en", i), 32'(cfg_rd_en), 32'(vt[i].x_crd));
            check($sformatf("vec%0d_rsp_wr_en", i), 32'(rsp_wr_en), 32'(vt[i].x_rsp));
            check($sformatf("vec%0d_rsp_din", i), rsp_din, vt[i].x_rdin);
            check($sformatf("vec%0d_outstanding", i), 32'(outstanding), 32'(vt[i].x_out));
            check($sformatf("vec%0d_err_orphan", i), 32'(err_orphan), 32'(vt[i].x_err));
        end

        do_reset();

        // Fairness with both requesters always ready
        for (int k = 0; k < 6; k++) begin
            rq0.push_back(32'h100 + k);
            rq1.push_back(32'h200 + k);
        end
        drain(200);
        check("fair_grant_count", 32'(grants.size()), 32'd12);
        for (int k = 0; k < grants.size(); k++) begin
            check($sformatf("fair_grant%0d", k), 32'(grants[k]), 32'(k % 2));
        end

        // Backpressure: stage held while the engine FIFO is full
        force_full = 1;
        for (int k = 0; k < 3; k++) rq0.push_back(32'h300 + k);
        cyc();
        check("bp_first_pop", 32'(req_rd_en), 32'd1);
        for (int k = 0; k < 5; k++) begin
            cyc();
            check("bp_din_stable", cfg_din, 32'h300);
            check("bp_no_pop", 32'(req_rd_en), 32'd0);
            check("bp_no_push", 32'(cfg_wr_en), 32'd0);
        end
        force_full = 0;
        cyc();
        check("bp_release_push", 32'(cfg_wr_en), 32'd1);
        check("bp_release_din", cfg_din, 32'h300);
        drain(200);

        // Credit limit: MAX_OUT pops with no responses, one more after a return
        hold_rsp = 1;
        for (int k = 0; k < 6; k++) rq0.push_back(32'h400 + k);
        pops = 0;
        for (int k = 0; k < 10; k++) begin
            cyc();
            if (req_rd_en != 0) pops++;
        end
        check("credit_pops", 32'(pops), 32'(MAX_OUT));
        check("credit_outstanding", 32'(outstanding), 32'(MAX_OUT));
        hold_rsp = 0;
        cyc();
        check("credit_return", 32'(cfg_rd_en), 32'd1);
        check("credit_no_pop_on_return", 32'(req_rd_en), 32'd0);
        hold_rsp = 1;
        cyc();
        check("credit_fifth_pop", 32'(req_rd_en), 32'd1);
        hold_rsp = 0;
        drain(200);

        // Head-of-line block on requester 1
        hold_rsp = 1;
        rq1.push_back(32'h500);
        cyc();
        check("hol_grant1", 32'(req_rd_en), 32'd2);
        rq0.push_back(32'h600);
        repeat (3) cyc();
        check("hol_outstanding", 32'(outstanding), 32'd2);
        rsp_full_v = 2'b10;
        hold_rsp = 0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            check("hol_blocked_rd", 32'(cfg_rd_en), 32'd0);
            check("hol_blocked_wr", 32'(rsp_wr_en), 32'd0);
        end
        rsp_full_v = 2'b00;
        cyc();
        check("hol_release_rd", 32'(cfg_rd_en), 32'd1);
        check("hol_release_wr", 32'(rsp_wr_en), 32'd2);
        drain(200);

        // Orphan response then a mid-burst reset
        eng_out.push_back(32'hDEAD);
        cyc();
        check("orphan_rd", 32'(cfg_rd_en), 32'd1);
        check("orphan_no_wr", 32'(rsp_wr_en), 32'd0);
        check("orphan_seen", 32'(orphans_seen), 32'd1);
        cyc();
        check("orphan_sticky", 32'(err_orphan), 32'd1);
        cyc();
        check("orphan_held", 32'(err_orphan), 32'd1);
        for (int k = 0; k < 4; k++) begin
            rq0.push_back(32'h700 + k);
            rq1.push_back(32'h800 + k);
        end
        repeat (3) cyc();
        do_reset();
        rq0.push_back(32'h900);
        rq1.push_back(32'h901);
        cyc();
        check("post_rst_first_grant", 32'(req_rd_en), 32'd1);
        drain(200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pciecfg_arb.md
# pciecfg_arb

Round-robin arbiter that shares the single PCIe configuration engine (`fifo_pciecfg_in` → `pciecfg_core` → `fifo_pciecfg_out`) among `NREQ` requesters. It pops requests from per-requester request FIFOs and forwards them one word at a time into the engine's input FIFO. It records the issuing requester in an in-order tag queue and steers each engine response back to that requester's response FIFO. It sits between the requester front ends (e.g. Ethernet-side config path, local management) and the `pciecfg` block.

## Interface
Parameters:
- `NREQ`, 2: number of requesters, 2..8.
- `MAX_OUT`, 4: maximum outstanding requests; tag queue depth; power of 2.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset; one clock, synchronous, active-high.
- `req_empty`  in  NREQ  request FIFO empty, per requester; FIFOs are first-word-fall-through.
- `req_rd_en`  out  NREQ  pop strobe into request FIFO i.
- `req_dout`  in  NREQ×FIFO_PCIECFG_T  head word of request FIFO i.
- `cfg_wr_en`  out  1  push into engine input FIFO.
- `cfg_full`  in  1  engine input FIFO full.
- `cfg_din`  out  FIFO_PCIECFG_T  word pushed to the engine.
- `cfg_rd_en`  out  1  pop from engine output FIFO (FWFT).
- `cfg_empty`  in  1  engine output FIFO empty.
- `cfg_dout`  in  FIFO_PCIECFG_T  engine response head word.
- `rsp_wr_en`  out  NREQ  push into response FIFO i.
- `rsp_full`  in  NREQ  response FIFO i full.
- `rsp_din`  out  FIFO_PCIECFG_T  response word, common to all requesters.
- `outstanding`  out  $clog2(MAX_OUT)+1  requests issued but not yet answered.
- `err_orphan`  out  1  sticky flag: a response arrived with no outstanding request.

## Operation
- Engine contract: exactly one response word per request word, returned in issue order.
- **Output stage:** one register (`stg_valid`, `stg_data`).
  - `cfg_wr_en = stg_valid & ~cfg_full`; `cfg_din = stg_data`.
  - The stage may load when `~stg_valid | cfg_wr_en`.
- **Issue:** in a cycle where the stage may load and `outstanding < MAX_OUT`, pick a grant `g`.
  - `g` is the first index i with `~req_empty[i]`, searching cyclically from `rr_ptr+1`.
  - Drive `req_rd_en[g]=1` combinationally. Load `stg_data <= req_dout[g]` and `stg_valid <= 1`.
  - Push `g` into the tag queue. Set `rr_ptr <= g`.
  - With no candidate: all `req_rd_en` are 0, and `stg_valid` clears if the stage was drained this cycle.
- `rr_ptr` changes only on an issue, never on idle cycles. At most one `req_rd_en` bit is high in any cycle.
- **Return path:** `t` = tag queue head.
  - With the queue non-empty, `~cfg_empty` and `~rsp_full[t]`:
    - `cfg_rd_en=1`, `rsp_wr_en[t]=1`, `rsp_din=cfg_dout`, all combinational.
    - Pop the tag queue.
  - A head response whose target is full blocks all later responses (in-order).
- **Orphan:** `~cfg_empty` with the tag queue empty → `cfg_rd_en=1`, no `rsp_wr_en`, word discarded, `err_orphan <= 1`. The flag holds until `rst`.
- **Counter:** `outstanding` increments on issue and decrements on return. Both in the same cycle leave it unchanged. It never exceeds `MAX_OUT` and never wraps. The tag queue read and write pointers wrap modulo `MAX_OUT`.

## Timing
- Reset values:
  - All `req_rd_en`, `cfg_wr_en`, `cfg_rd_en`, `rsp_wr_en` = 0.
  - `stg_valid` = 0, `cfg_din`/`rsp_din` = 0, `outstanding` = 0, `err_orphan` = 0.
  - `rr_ptr` = NREQ-1, so requester 0 wins first.
  - Tag queue empty.
- `rst` during an active transfer discards the stage word and all tags. The engine is reset by the same `rst`.
- Request latency: pop in cycle N, `cfg_wr_en` in cycle N+1 if `~cfg_full`. Sustained throughput is 1 word/cycle.
- While `cfg_full` holds, `stg_data` is held stable and no new pop occurs.
- Response latency: zero cycles from FWFT `cfg_dout` to `rsp_wr_en`.
- Simultaneous issue and return in one cycle are both honoured, including when the queue is full with `outstanding == MAX_OUT`: the return frees a slot only from the next cycle.

## Structure
- `pciecfg_pkg`: `FIFO_PCIECFG_T` (existing). Add `PCIECFG_NREQ` and `PCIECFG_MAX_OUT` as default constants.
- Sub-module `pciecfg_tagq`: a `MAX_OUT`-deep FIFO of `$clog2(NREQ)`-bit tags, with push, pop, head, empty, full and count.
- The arbiter and stage live in `pciecfg_arb`. Expected size is about 200 lines of RTL.

## Test plan
- **Single request:** req0 word 0xA1 after reset → `req_rd_en[0]` cycle 0, `cfg_wr_en` with 0xA1 cycle 1, `outstanding`=1. Response 0xB1 → `rsp_wr_en[0]`, `rsp_din`=0xB1, `outstanding`=0.
- **Fairness:** both requesters never empty → grants 0,1,0,1,…. The loopback engine returns responses to 0,1,0,1 in order with the correct data.
- **Backpressure:** `cfg_full` high for 5 cycles with the stage loaded → `cfg_din` stable, no `req_rd_en`. After release, a push in the first free cycle.
- **Credit limit:** MAX_OUT=4 with no responses → exactly 4 pops, then none. One response → a 5th pop the following cycle.
- **Head-of-line block:** head tag=1 with `rsp_full[1]` high for 3 cycles → `cfg_rd_en`=0 throughout. On release, delivery to requester 1 in the same cycle.
- **Orphan and reset:** response with the queue empty → `cfg_rd_en`=1, no `rsp_wr_en`, `err_orphan`=1 and held. Mid-burst `rst` → every reset value above on the next cycle.
